uart_tx: RTL and testbench
==========================

Name: uart_tx

Overview:
Serial UART transmitter, the transmit-side counterpart of the team's UART receiver. It accepts a parallel byte plus per-frame configuration and serialises it onto a single line: start bit, 5–8 data bits LSB-first, optional parity, then 1 or 2 stop bits. Each bit is held for CLKS_PER_BIT clocks. With the default of 16, the line timing matches the receiver's 16x mid-bit sampling on the same clock.

Parameters:
CLKS_PER_BIT, 16, tx_clk cycles per serial bit (legal range 2..256; counter width = clog2(CLKS_PER_BIT))

Ports:
tx_clk  in  1  sole clock; all logic on posedge
rst  in  1  asynchronous, active-high reset
tx_start  in  1  frame request; sampled only in IDLE
tx_data  in  8  payload; bit 0 is sent first; bits above data_len are ignored
parity_en  in  1  1 = insert a parity bit after the data
parity_type  in  1  1 = even parity (bit = XOR of data bits); 0 = odd parity (bit = XNOR)
data_len  in  4  data bits per frame: 5, 6, 7 or 8; any other value is treated as 8
stop2  in  1  1 = two stop bits; 0 = one stop bit
tx  out  1  serial line; idle/mark = 1
tx_busy  out  1  high from the cycle after acceptance through the last stop-bit cycle
tx_done  out  1  one-cycle pulse; frame complete

Behaviour:
- Reset (async, any time, including mid-frame): tx=1, tx_busy=0, tx_done=0, state=IDLE, all counters and shadow registers cleared. The partial frame is abandoned.
- Acceptance: in IDLE with tx_start=1, the block latches tx_data, parity_en, parity_type, stop2 and data_len (normalised) into shadow registers. It also computes the parity bit over the data_len LSBs only and latches it. Input changes after acceptance do not affect the frame.
- tx_start is ignored outside IDLE. No queueing, no error flag.
- Latency: tx falls to 0 on the first clock edge after acceptance. tx_busy rises on that same edge.
- Bit timer: counter runs 0..CLKS_PER_BIT-1. A state advances only when the counter reaches CLKS_PER_BIT-1, and the counter resets to 0 on each advance. tx is registered and holds one value per bit period.
- States and transitions:
  - IDLE: tx=1. Go to START on acceptance.
  - START: tx=0 for one bit period, then go to DATA.
  - DATA: tx = shadow[bit_idx], bit_idx counts 0..N-1. After bit N-1, go to PARITY if parity_en, else STOP1.
  - PARITY: tx = latched parity bit for one bit period, then go to STOP1.
  - STOP1: tx=1. Go to STOP2 if stop2, else to IDLE with tx_done=1.
  - STOP2: tx=1, then go to IDLE with tx_done=1.
- tx_done is high for exactly the first IDLE cycle after the frame, and tx_busy is 0 in that cycle.
- Back-to-back: tx_start in the tx_done cycle is accepted, so the next start bit begins immediately with zero idle gap.
- Frame length in cycles = (1 + N + parity_en + 1 + stop2) * CLKS_PER_BIT. Example: 8N1 at 16 gives 160 cycles.
- Data bits above data_len are never transmitted and never enter the parity.
- Unreachable state encodings go to IDLE with tx=1.

Decomposition:
- Package uart_pkg:
  - state enum (IDLE, START, DATA, PARITY, STOP1, STOP2), shared with the receiver;
  - constants UART_OVERSAMPLE=16, DLEN_MIN=5, DLEN_MAX=8;
  - function calc_parity(data, len, type), shared with the receiver so both ends use the same parity rule.
- Sub-module uart_bit_timer: parameterised CLKS_PER_BIT counter with clear input and a bit_end output. Reusable by the receiver.

Test Plan:
- 8N1: tx_data=8'hA5, data_len=8, parity_en=0, stop2=0. Required: tx = 0,1,0,1,0,0,1,0,1,1, each held 16 cycles; tx_done pulses at cycle 161 after acceptance; tx_busy high for 160 cycles.
- 7E2: tx_data=8'hFF, data_len=7, parity_en=1, parity_type=1, stop2=1. Required: start, then 7 ones, then parity=1, then two stop bits; bit 7 is not sent; frame = 176 cycles.
- 5O1 plus illegal length:
  - data_len=5, tx_data=8'h13, parity_type=0: parity bit = 0 (three ones → XNOR = 0).
  - Repeat with data_len=4'd3: frame behaves exactly as data_len=8.
- Back-to-back and busy-ignore:
  - Assert tx_start in the tx_done cycle with 8'h3C: next start bit begins the next cycle, no mark gap.
  - tx_start pulsed mid-frame: no effect.
- Reset mid-frame: assert rst during the 3rd data bit. Required: tx=1, tx_busy=0 immediately (asynchronous); after release, a new tx_start=8'h55 produces a clean full frame.
- Loopback: connect tx to the receiver on the same clock and configuration, sweep all 256 bytes × lengths 5–8 × parity on/off × stop 1/2. Required: receiver data = tx_data masked to data_len, no receiver error.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: frame state encoding, frame-size limits and the
// parity rule used by both the transmitter and the receiver.
package uart_pkg;

  localparam int UART_OVERSAMPLE = 16;
  localparam int DLEN_MIN        = 5;
  localparam int DLEN_MAX        = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP1  = 3'd4,
    STOP2  = 3'd5
  } uart_state_e;

  // Any length outside 5..8 is treated as a full byte.
  function automatic logic [3:0] norm_len(input logic [3:0] len);
    if (len >= 4'(DLEN_MIN) && len <= 4'(DLEN_MAX)) begin
      return len;
    end
    return 4'(DLEN_MAX);
  endfunction

  // Even parity = XOR of the active data bits, odd parity = XNOR.
  function automatic logic calc_parity(input logic [7:0] data,
                                       input logic [3:0] len,
                                       input logic       parity_type);
    logic [7:0] mask;
    mask = 8'hFF >> (4'd8 - norm_len(len));
    return parity_type ? ^(data & mask) : ~^(data & mask);
  endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Parallel-side and line-side signals of the UART transmitter.
interface uart_tx_if;

  logic       tx_start;
  logic [7:0] tx_data;
  logic       parity_en;
  logic       parity_type;
  logic [3:0] data_len;
  logic       stop2;
  logic       tx;
  logic       tx_busy;
  logic       tx_done;

  modport master (
    output tx_start, tx_data, parity_en, parity_type, data_len, stop2,
    input  tx, tx_busy, tx_done
  );

  modport slave (
    input  tx_start, tx_data, parity_en, parity_type, data_len, stop2,
    output tx, tx_busy, tx_done
  );

endinterface

// File: rtl/uart_bit_timer.sv
// Bit-period counter: runs 0..CLKS_PER_BIT-1 and flags the last cycle of
// each period; held at zero while clear_i is high.
module uart_bit_timer #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  output logic bit_end_o
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clear_i || cnt_q == LAST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  assign bit_end_o = (cnt_q == LAST) && !clear_i;

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, 5..8 data bits LSB-first, optional parity,
// one or two stop bits, each bit held for CLKS_PER_BIT clocks.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_OVERSAMPLE
) (
  input  logic     tx_clk,
  input  logic     rst,
  uart_tx_if.slave bus
);

  uart_state_e state_q;
  logic [7:0]  data_q;
  logic [3:0]  dlen_q;
  logic        par_en_q;
  logic        par_bit_q;
  logic        stop2_q;
  logic [2:0]  bit_idx_q;
  logic        tx_q;
  logic        busy_q;
  logic        done_q;

  logic        bit_end;
  logic [2:0]  last_idx;

  assign last_idx = 3'(dlen_q - 4'd1);

  // The timer is parked at zero in IDLE so a start bit always gets a full period.
  uart_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk      (tx_clk),
    .rst      (rst),
    .clear_i  (state_q == IDLE),
    .bit_end_o(bit_end)
  );

  always_ff @(posedge tx_clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      data_q    <= '0;
      dlen_q    <= '0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      stop2_q   <= 1'b0;
      bit_idx_q <= '0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          tx_q   <= 1'b1;
          busy_q <= 1'b0;
          if (bus.tx_start) begin
            data_q    <= bus.tx_data;
            dlen_q    <= norm_len(bus.data_len);
            par_en_q  <= bus.parity_en;
            par_bit_q <= calc_parity(bus.tx_data, bus.data_len, bus.parity_type);
            stop2_q   <= bus.stop2;
            bit_idx_q <= '0;
            tx_q      <= 1'b0;
            busy_q    <= 1'b1;
            state_q   <= START;
          end
        end
        START: begin
          if (bit_end) begin
            tx_q    <= data_q[0];
            state_q <= DATA;
          end
        end
        DATA: begin
          if (bit_end) begin
            if (bit_idx_q == last_idx) begin
              if (par_en_q) begin
                tx_q    <= par_bit_q;
                state_q <= PARITY;
              end else begin
                tx_q    <= 1'b1;
                state_q <= STOP1;
              end
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
              tx_q      <= data_q[bit_idx_q + 3'd1];
            end
          end
        end
        PARITY: begin
          if (bit_end) begin
            tx_q    <= 1'b1;
            state_q <= STOP1;
          end
        end
        STOP1: begin
          if (bit_end) begin
            if (stop2_q) begin
              state_q <= STOP2;
            end else begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= IDLE;
            end
          end
        end
        STOP2: begin
          if (bit_end) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: begin
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.tx      = tx_q;
  assign bus.tx_busy = busy_q;
  assign bus.tx_done = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: stimulus queues the expected line waveform of
// each frame, a monitor follows the line cycle by cycle and compares.
module tb_uart_tx;

  localparam int CPB = 16;

  logic tx_clk;
  logic rst;

  uart_tx_if bus ();

  uart_tx #(
    .CLKS_PER_BIT(CPB)
  ) dut (
    .tx_clk(tx_clk),
    .rst   (rst),
    .bus   (bus)
  );

  initial tx_clk = 1'b0;
  always #5 tx_clk = ~tx_clk;

  typedef struct {
    logic [11:0] bits;   // line values per bit period, start bit at [0]
    int          nbits;
    bit          b2b;    // issued in the tx_done cycle of the previous frame
  } exp_t;

  exp_t exp_q[$];
  int   cmp_cnt = 0;
  int   err_cnt = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
    cmp_cnt++;
    if (got !== req) begin
      err_cnt++;
      $display("FAIL %s: got %0h required %0h", name, got, req);
    end
  endtask

  // Reference frame builder for the sweep.
  function automatic void build_frame(input logic [7:0] d, input int n, input bit pen,
                                      input bit ptype, input bit s2,
                                      output logic [11:0] bits, output int nb);
    int ones;
    ones = 0;
    bits = '1;
    bits[0] = 1'b0;
    for (int i = 0; i < n; i++) begin
      bits[1 + i] = d[i];
      ones += int'(d[i]);
    end
    nb = 1 + n;
    if (pen) begin
      bits[nb] = ptype ? ones[0] : ~ones[0];
      nb++;
    end
    nb += s2 ? 2 : 1;
  endfunction

  task automatic send(input logic [7:0] d, input logic [3:0] len, input bit pen,
                      input bit ptype, input bit s2, input logic [11:0] bits,
                      input int nb, input bit b2b);
    exp_t e;
    e.bits  = bits;
    e.nbits = nb;
    e.b2b   = b2b;
    exp_q.push_back(e);
    bus.tx_data     = d;
    bus.data_len    = len;
    bus.parity_en   = pen;
    bus.parity_type = ptype;
    bus.stop2       = s2;
    bus.tx_start    = 1'b1;
    @(posedge tx_clk);
    #1;
    bus.tx_start    = 1'b0;
    // Scramble inputs so the frame must come from the latched copies.
    bus.tx_data     = ~d;
    bus.data_len    = 4'd5;
    bus.parity_en   = ~pen;
    bus.parity_type = ~ptype;
    bus.stop2       = ~s2;
  endtask

  task automatic wait_done(input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(posedge tx_clk);
      #1;
      if (bus.tx_done === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      cmp_cnt++;
      err_cnt++;
      $display("FAIL %s_timeout: got no tx_done required tx_done within 400 cycles", name);
    end
  endtask

  // Monitor: follows each frame from its start bit to the tx_done cycle.
  initial begin : monitor
    exp_t e;
    bit   bad;
    bit   aborted;
    bit   expect_b2b;
    logic bad_tx;
    logic bad_busy;
    int   fnum;
    int   nbad;
    fnum       = 0;
    expect_b2b = 1'b0;
    forever begin
      @(negedge tx_clk);
      if (rst) begin
        expect_b2b = 1'b0;
        continue;
      end
      if (expect_b2b) begin
        check($sformatf("b2b_gap_frame%0d", fnum), 32'(bus.tx), 32'(1'b0));
        expect_b2b = 1'b0;
      end
      if (bus.tx === 1'b0) begin
        if (exp_q.size() == 0) begin
          check("unexpected_start", 32'(bus.tx), 32'(1'b1));
          continue;
        end
        e       = exp_q.pop_front();
        aborted = 1'b0;
        nbad    = 0;
        for (int k = 0; k < e.nbits && !aborted; k++) begin
          bad      = 1'b0;
          bad_tx   = 1'b0;
          bad_busy = 1'b0;
          for (int c = 0; c < CPB; c++) begin
            if (!(k == 0 && c == 0)) @(negedge tx_clk);
            if (rst) begin
              aborted = 1'b1;
              break;
            end
            if (!bad && (bus.tx !== e.bits[k] || bus.tx_busy !== 1'b1)) begin
              bad      = 1'b1;
              bad_tx   = bus.tx;
              bad_busy = bus.tx_busy;
            end
          end
          if (!aborted) begin
            cmp_cnt++;
            if (bad) begin
              err_cnt++;
              nbad++;
              $display("FAIL frame%0d_bit%0d: got line=%b busy=%b required line=%b busy=1",
                       fnum, k, bad_tx, bad_busy, e.bits[k]);
            end
          end
        end
        if (!aborted) begin
          @(negedge tx_clk);
          check($sformatf("frame%0d_done", fnum),
                {29'd0, bus.tx_done, bus.tx_busy, bus.tx}, 32'b101);
          if (exp_q.size() > 0 && exp_q[0].b2b) expect_b2b = 1'b1;
          $display("frame %0d: %0d bits checked, %0d bad bits", fnum, e.nbits, nbad);
        end else begin
          $display("frame %0d: abandoned by reset", fnum);
        end
        fnum++;
      end else if (bus.tx_done === 1'b1) begin
        check("unexpected_done", 32'(bus.tx_done), 32'(1'b0));
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: got no end of test required finish before 1 ms");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    logic [11:0] bits;
    int          nb;
    logic [7:0]  d;
    rst             = 1'b1;
    bus.tx_start    = 1'b0;
    bus.tx_data     = 8'h00;
    bus.data_len    = 4'd8;
    bus.parity_en   = 1'b0;
    bus.parity_type = 1'b0;
    bus.stop2       = 1'b0;
    repeat (3) @(posedge tx_clk);
    #1;
    check("reset_tx", 32'(bus.tx), 32'(1'b1));
    check("reset_busy", 32'(bus.tx_busy), 32'(1'b0));
    check("reset_done", 32'(bus.tx_done), 32'(1'b0));
    #2 rst = 1'b0;
    @(posedge tx_clk);
    #1;

    // 8N1 0xA5: 0,1,0,1,0,0,1,0,1,1
    send(8'hA5, 4'd8, 1'b0, 1'b0, 1'b0, 12'h34A, 10, 1'b0);
    wait_done("8N1_A5");
    // 7E2 0xFF: start, seven ones, parity 1, two stops; bit 7 dropped
    send(8'hFF, 4'd7, 1'b1, 1'b1, 1'b1, 12'h7FE, 11, 1'b1);
    wait_done("7E2_FF");
    // 5O1 0x13: data 1,1,0,0,1 -> odd parity 0
    send(8'h13, 4'd5, 1'b1, 1'b0, 1'b0, 12'h0A6, 8, 1'b1);
    wait_done("5O1_13");
    // Illegal length 3 behaves as 8: data 1,1,0,0,1,0,0,0 -> odd parity 0
    send(8'h13, 4'd3, 1'b1, 1'b0, 1'b0, 12'h426, 11, 1'b1);
    wait_done("len3_13");

    // Mid-frame tx_start must be ignored.
    repeat (3) @(posedge tx_clk);
    #1;
    send(8'hA5, 4'd8, 1'b0, 1'b0, 1'b0, 12'h34A, 10, 1'b0);
    repeat (40) @(posedge tx_clk);
    #1;
    bus.tx_start = 1'b1;
    bus.tx_data  = 8'h00;
    @(posedge tx_clk);
    #1;
    bus.tx_start = 1'b0;
    wait_done("busy_ignore");

    // Back-to-back: 6N1 0x0F then 8N1 0x3C issued in the tx_done cycle.
    repeat (3) @(posedge tx_clk);
    #1;
    send(8'h0F, 4'd6, 1'b0, 1'b0, 1'b0, 12'h09E, 8, 1'b0);
    wait_done("b2b_first");
    send(8'h3C, 4'd8, 1'b0, 1'b0, 1'b0, 12'h278, 10, 1'b1);
    wait_done("b2b_second");

    // Reset during the third data bit of 8N1 0xC3.
    repeat (3) @(posedge tx_clk);
    #1;
    send(8'hC3, 4'd8, 1'b0, 1'b0, 1'b0, 12'h386, 10, 1'b0);
    repeat (54) @(posedge tx_clk);
    #2;
    rst = 1'b1;
    #1;
    check("midreset_tx", 32'(bus.tx), 32'(1'b1));
    check("midreset_busy", 32'(bus.tx_busy), 32'(1'b0));
    @(posedge tx_clk);
    @(posedge tx_clk);
    #3 rst = 1'b0;
    @(posedge tx_clk);
    #1;
    check("postreset_idle", {30'd0, bus.tx_busy, bus.tx}, 32'b01);
    send(8'h55, 4'd8, 1'b0, 1'b0, 1'b0, 12'h2AA, 10, 1'b0);
    wait_done("after_reset_55");

    // Configuration sweep with random payloads, all back-to-back.
    for (int i = 0; i < 32; i++) begin
      d = 8'($urandom);
      build_frame(d, 5 + (i % 4), i[2], i[3], i[4], bits, nb);
      send(d, 4'(5 + (i % 4)), i[2], i[3], i[4], bits, nb, 1'b1);
      wait_done($sformatf("sweep%0d", i));
    end

    repeat (5) @(posedge tx_clk);
    #1;
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
